muldiv_unit: RTL

Iterative RV32M multiply/divide unit in the Execute stage and the producer of `multiInstrStall` consumed by the hazard unit. It accepts one M-extension operation from Execute, holds `multiInstrStall` high while it iterates one bit per cycle, then presents a 32-bit result for exactly one cycle so the instruction can advance to Memory. Division-by-zero and signed-overflow cases are resolved on a one-cycle fast path.

---
 rtl/muldiv_unit.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit - iterative RV32M multiply/divide unit for the Execute stage.
//
// One M-extension operation is accepted from Execute. The unit stalls the
// front of the pipeline while it iterates one bit per cycle, then shows the
// result for exactly one cycle. Divide-by-zero and signed overflow finish on
// a one-cycle fast path.
//
// Ports:
//   clk             clock, all state updates on the rising edge
//   reset_n         synchronous active-low reset
//   StartE          valid M-extension instruction in Execute
//   FunctE[2:0]     funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//   SrcAE, SrcBE    rs1 / rs2 operands (post-forwarding), sampled at accept
//   KillE           abort the in-flight operation (priority over StartE)
//   multiInstrStall stall request to the hazard unit
//   DoneE           result valid this cycle
//   ResultE         operation result, held outside DONE
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             StartE,
  input  logic [2:0]       FunctE,
  input  logic [WIDTH-1:0] SrcAE,
  input  logic [WIDTH-1:0] SrcBE,
  input  logic             KillE,
  output logic             multiInstrStall,
  output logic             DoneE,
  output logic [WIDTH-1:0] ResultE
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2:0]          funct_q, funct_d;
  logic                neg_q, neg_d;         // product / quotient sign
  logic                rem_neg_q, rem_neg_d; // remainder follows dividend
  logic [WIDTH-1:0]    opb_q, opb_d;         // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]    result_q, result_d;

  // ---------------------------------------------------------------------
  // Accept-time decode of the incoming operation
  // ---------------------------------------------------------------------
  logic             in_is_div;
  logic             in_a_signed, in_b_signed;
  logic             in_a_neg, in_b_neg;
  logic [WIDTH-1:0] in_a_mag, in_b_mag;
  logic             in_div_zero, in_overflow, in_fast;
  logic [WIDTH-1:0] in_fast_result;

  always_comb begin
    in_is_div   = FunctE[2];
    // MUL's low half is sign-agnostic, but treating it as signed is harmless.
    in_a_signed = (FunctE == 3'd0) || (FunctE == 3'd1) || (FunctE == 3'd2) ||
                  (FunctE == 3'd4) || (FunctE == 3'd6);
    in_b_signed = (FunctE == 3'd0) || (FunctE == 3'd1) ||
                  (FunctE == 3'd4) || (FunctE == 3'd6);
    in_a_neg    = in_a_signed && SrcAE[WIDTH-1];
    in_b_neg    = in_b_signed && SrcBE[WIDTH-1];
    // The most negative value negates to itself, which is its correct
    // unsigned magnitude.
    in_a_mag    = in_a_neg ? (~SrcAE + 1'b1) : SrcAE;
    in_b_mag    = in_b_neg ? (~SrcBE + 1'b1) : SrcBE;

    in_div_zero = in_is_div && (SrcBE == '0);
    in_overflow = in_is_div && !FunctE[0] &&
                  (SrcAE == {1'b1, {(WIDTH-1){1'b0}}}) && (SrcBE == '1);
    in_fast     = in_div_zero || in_overflow;

    if (in_div_zero) begin
      in_fast_result = FunctE[1] ? SrcAE : '1;
    end else begin
      in_fast_result = FunctE[1] ? '0 : {1'b1, {(WIDTH-1){1'b0}}};
    end
  end

  // ---------------------------------------------------------------------
  // One iteration step on the registered accumulator
  // ---------------------------------------------------------------------
  logic [WIDTH:0]      mul_sum;
  logic [2*WIDTH-1:0]  mul_next;
  logic [WIDTH:0]      div_rshift, div_diff;
  logic                div_fits;
  logic [2*WIDTH-1:0]  div_next;
  logic [2*WIDTH-1:0]  step;
  logic [2*WIDTH-1:0]  prod_signed;
  logic [WIDTH-1:0]    quot_signed, rem_signed;
  logic [WIDTH-1:0]    final_result;

  always_comb begin
    // Shift-add: low half holds the remaining multiplier bits, high half the
    // partial product; the carry rides into the shift.
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Restoring division: {remainder, dividend/quotient} shifts left; the
    // shifted remainder needs WIDTH+1 bits before the trial subtract.
    div_rshift = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff   = div_rshift - {1'b0, opb_q};
    div_fits   = !div_diff[WIDTH];
    div_next   = {(div_fits ? div_diff[WIDTH-1:0] : div_rshift[WIDTH-1:0]),
                  acc_q[WIDTH-2:0], div_fits};

    step = funct_q[2] ? div_next : mul_next;

    // Sign correction is applied once, on the final step.
    prod_signed = neg_q ? (~step + 1'b1) : step;
    quot_signed = neg_q ? (~step[WIDTH-1:0] + 1'b1) : step[WIDTH-1:0];
    rem_signed  = rem_neg_q ? (~step[2*WIDTH-1:WIDTH] + 1'b1)
                            : step[2*WIDTH-1:WIDTH];

    if (funct_q[2]) begin
      final_result = funct_q[1] ? rem_signed : quot_signed;
    end else begin
      final_result = (funct_q[1:0] == 2'd0) ? prod_signed[WIDTH-1:0]
                                            : prod_signed[2*WIDTH-1:WIDTH];
    end
  end

  // ---------------------------------------------------------------------
  // Next-state / output logic
  // ---------------------------------------------------------------------
  logic stall;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    funct_d   = funct_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    opb_d     = opb_q;
    acc_d     = acc_q;
    result_d  = result_q;
    stall     = 1'b0;

    if (KillE) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (StartE) begin
            stall     = 1'b1;
            funct_d   = FunctE;
            neg_d     = in_a_neg ^ in_b_neg;
            rem_neg_d = in_a_neg;
            opb_d     = in_b_mag;
            acc_d     = {{WIDTH{1'b0}}, in_a_mag};
            cnt_d     = CW'(WIDTH-1);
            if (in_fast) begin
              state_d  = DONE;
              result_d = in_fast_result;
            end else begin
              state_d = BUSY;
            end
          end
        end
        BUSY: begin
          stall = 1'b1;
          acc_d = step;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == '0) begin
            state_d  = DONE;
            result_d = final_result;
          end
        end
        DONE: begin
          // The instruction that produced this result is still in Execute,
          // so StartE is deliberately ignored here.
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      funct_q   <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      opb_q     <= '0;
      acc_q     <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      funct_q   <= funct_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      opb_q     <= opb_d;
      acc_q     <= acc_d;
      result_q  <= result_d;
    end
  end

  // Reset holds the stall low even if StartE is asserted meanwhile.
  assign multiInstrStall = stall && reset_n;
  assign DoneE           = (state_q == DONE);
  assign ResultE         = result_q;

endmodule
